tb_reset_seq: RTL and testbench
===============================

// Module: tb_reset_seq
// PURPOSE
//  Testbench reset sequencer. Sits directly downstream of the bench clock generator and
//  consumes its clock output. Produces NUM_RESETS staged, active-high resets for the DUT
//  domains, released in order 0..NUM_RESETS-1.
//  Also provides a post-release cycle counter that bench classes use as a time base.
// PARAMETERS
//  NUM_RESETS     4   number of staged reset outputs (1..16)
//  ASSERT_CYCLES  8   cycles all resets stay asserted before stage 0 releases (>=1)
//  STAGE_GAP      4   cycles between consecutive stage releases (>=1)
//  CNT_W          16  width of cycle_count
// PORTS
//  clock         in   1           bench clock; single clock domain, all logic on rising edge
//  reset         in   1           synchronous, active-high master reset
//  sw_reset_req  in   1           1-cycle pulse; restart the full sequence
//  hold          in   1           while high in ASSERT, freeze the assert countdown
//  reset_out     out  NUM_RESETS  staged resets, active-high, registered
//  all_released  out  1           high once every reset_out bit is low
//  busy          out  1           high in ASSERT or RELEASE
//  cycle_count   out  CNT_W       cycles since all_released rose; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=1 sampled at an edge):
//   reset_out = all ones, all_released = 0, busy = 1, cycle_count = 0.
//   State = ASSERT; internal counter = 0.
//  FSM states: ASSERT -> RELEASE -> RUN.
//  ASSERT:
//   - Counter increments each edge unless hold=1 (frozen).
//   - When counter reaches ASSERT_CYCLES-1 with hold=0:
//     * the next edge clears reset_out[0];
//     * counter is cleared and the state moves to RELEASE.
//   - Timing: with hold low, reset_out[0] falls at edge T0+ASSERT_CYCLES, where T0 is the
//     first edge sampling reset=0.
//  RELEASE:
//   - reset_out[i] falls at edge T0 + ASSERT_CYCLES + i*STAGE_GAP.
//   - hold is ignored.
//   - Released bits never re-assert except via reset or sw_reset_req.
//  Entry to RUN:
//   - At the edge that clears reset_out[NUM_RESETS-1]: all_released=1, busy=0, state=RUN.
//   - NUM_RESETS=1: stage 0's release edge enters RUN directly.
//  RUN:
//   - cycle_count increments by 1 per edge, starting with the edge after all_released rises.
//   - Stops at 2**CNT_W-1; no wrap.
//  sw_reset_req=1 in any state:
//   - Next edge: reset_out = all ones, all_released = 0, busy = 1, cycle_count = 0.
//   - Counter cleared; state = ASSERT. The sequence then repeats with T0 = that edge.
//  Precedence: reset > sw_reset_req > hold > normal counting.
//  sw_reset_req held high for several cycles keeps the block in ASSERT at count 0.
//  Reset mid-sequence (ASSERT or RELEASE): immediate return to the reset values; no partial state kept.
//  All outputs are registered; no combinational path from inputs to outputs.
//  reset_out is monotonic within one sequence: each bit makes exactly one 1->0 transition.
// TESTING
//  1 Defaults; reset high 3 edges, then low at edge T0:
//     reset_out 1111 -> 1110@T0+8 -> 1100@T0+12 -> 1000@T0+16 -> 0000@T0+20.
//     all_released=1 and busy=0 @T0+20.
//  2 hold=1 for 5 cycles during ASSERT:
//     every release edge shifts by +5 (stage 0 @T0+13, all_released @T0+25).
//     hold=1 during RELEASE: no shift.
//  3 sw_reset_req pulse at RUN, cycle_count=37:
//     next edge reset_out=1111, cycle_count=0, busy=1.
//     stage 0 releases 8 edges after that.
//  4 reset asserted while reset_out=1100:
//     next edge reset_out=1111, all_released=0.
//     after reset drops, a full sequence with case-1 timing.
//  5 CNT_W=4, run 20 cycles past all_released: cycle_count reaches 15 and holds 15.
//  6 NUM_RESETS=1, ASSERT_CYCLES=1: reset_out falls at T0+1, all_released rises at the same edge.

Source files
------------

// File: rtl/tb_reset_seq.sv
// Staged reset sequencer for bench DUT domains.
// Resets are released in order 0..NUM_RESETS-1, and a saturating post-release cycle counter runs afterwards.
module tb_reset_seq #(
  parameter int NUM_RESETS    = 4,
  parameter int ASSERT_CYCLES = 8,
  parameter int STAGE_GAP     = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic                  hold,
  output logic [NUM_RESETS-1:0] reset_out,
  output logic                  all_released,
  output logic                  busy,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int MAXC = (ASSERT_CYCLES > STAGE_GAP) ? ASSERT_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  // The counter holds the number of sequence edges already taken. Stage 0 drops on the edge
  // after the counter reaches ASSERT_CYCLES. The edge that starts a new sequence counts as one.
  localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [NUM_RESETS-1:0]   rst_q;
  logic                    all_q;
  logic                    busy_q;
  logic [CNT_W-1:0]        ccnt_q;

  logic                    step;
  logic [NUM_RESETS-1:0]   rst_shift;

  assign rst_shift = rst_q << 1;
  assign step = ((state_q == ST_ASSERT) && !hold && (cnt_q == ASSERT_LAST)) ||
                ((state_q == ST_RELEASE) && (cnt_q == GAP_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      ccnt_q  <= '0;
    end else if (sw_reset_req) begin
      state_q <= ST_ASSERT;
      cnt_q   <= CW'(1);
      rst_q   <= '1;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      ccnt_q  <= '0;
    end else begin
      case (state_q)
        ST_ASSERT, ST_RELEASE: begin
          if (step) begin
            cnt_q <= '0;
            rst_q <= rst_shift;
            if (rst_shift == '0) begin
              state_q <= ST_RUN;
              all_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_RELEASE;
            end
          end else if (state_q == ST_RELEASE || !hold) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (ccnt_q != '1) ccnt_q <= ccnt_q + CNT_W'(1);
        end
        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  assign reset_out    = rst_q;
  assign all_released = all_q;
  assign busy         = busy_q;
  assign cycle_count  = ccnt_q;

endmodule

// File: tb/tb_tb_reset_seq.sv
// Directed bench for tb_reset_seq: default, narrow-counter and single-stage instances.
module tb_tb_reset_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, sw_a, hold_a;
  logic [3:0]  ro_a;
  logic        all_a, busy_a;
  logic [15:0] cnt_a;

  logic rst_b, sw_b, hold_b;
  logic [3:0]  ro_b;
  logic        all_b, busy_b;
  logic [3:0]  cnt_b;

  logic rst_c, sw_c, hold_c;
  logic [0:0]  ro_c;
  logic        all_c, busy_c;
  logic [15:0] cnt_c;

  tb_reset_seq u_a (
    .clock(clock), .reset(rst_a), .sw_reset_req(sw_a), .hold(hold_a),
    .reset_out(ro_a), .all_released(all_a), .busy(busy_a), .cycle_count(cnt_a));

  tb_reset_seq #(.CNT_W(4)) u_b (
    .clock(clock), .reset(rst_b), .sw_reset_req(sw_b), .hold(hold_b),
    .reset_out(ro_b), .all_released(all_b), .busy(busy_b), .cycle_count(cnt_b));

  tb_reset_seq #(.NUM_RESETS(1), .ASSERT_CYCLES(1)) u_c (
    .clock(clock), .reset(rst_c), .sw_reset_req(sw_c), .hold(hold_c),
    .reset_out(ro_c), .all_released(all_c), .busy(busy_c), .cycle_count(cnt_c));

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst, sw, hold;
    logic [3:0]  ro;
    logic        all, busy;
    logic [15:0] cnt;
  } vec_t;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Expected state k edges after T0 for the default instance; stage 0 drops at T0+base.
  function automatic vec_t mk(logic r, logic s, logic h, int k, int base);
    vec_t v;
    v.rst = r; v.sw = s; v.hold = h;
    if (r || s) begin
      v.ro = 4'hf; v.all = 1'b0; v.busy = 1'b1; v.cnt = '0;
    end else begin
      for (int i = 0; i < 4; i++) v.ro[i] = (k < base + 4 * i);
      v.all  = (k >= base + 12);
      v.busy = !v.all;
      v.cnt  = (k > base + 12) ? 16'(k - base - 12) : 16'd0;
    end
    return v;
  endfunction

  task automatic apply(vec_t v, string tag);
    rst_a = v.rst; sw_a = v.sw; hold_a = v.hold;
    @(posedge clock); #1;
    chk({tag, " reset_out"},    32'(ro_a),   32'(v.ro));
    chk({tag, " all_released"}, 32'(all_a),  32'(v.all));
    chk({tag, " busy"},         32'(busy_a), 32'(v.busy));
    chk({tag, " cycle_count"},  32'(cnt_a),  32'(v.cnt));
  endtask

  initial begin
    vec_t tbl[$];
    rst_a = 1'b1; sw_a = 1'b0; hold_a = 1'b0;
    rst_b = 1'b1; sw_b = 1'b0; hold_b = 1'b0;
    rst_c = 1'b1; sw_c = 1'b0; hold_c = 1'b0;

    // Plain sequence, then a sequence with hold in ASSERT (+5) and in RELEASE (no shift), run to count 37
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 0, 8));
    for (int k = 0; k <= 24; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b0, k, 8));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 0, 8));
    for (int k = 0; k <= 62; k++)
      tbl.push_back(mk(1'b0, 1'b0, ((k >= 2 && k <= 6) || (k >= 14 && k <= 16)), k, 13));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Software restart from RUN at cycle_count 37, then stop when reset_out is 1100
    apply(mk(1'b0, 1'b1, 1'b0, 0, 8), "sw_pulse");
    for (int k = 1; k <= 12; k++) apply(mk(1'b0, 1'b0, 1'b0, k, 8), $sformatf("after_sw k%0d", k));

    // Master reset mid-release, then a full sequence with default timing
    apply(mk(1'b1, 1'b0, 1'b0, 0, 8), "mid_reset");
    for (int k = 0; k <= 21; k++) apply(mk(1'b0, 1'b0, 1'b0, k, 8), $sformatf("post_reset k%0d", k));

    // Request held for 3 edges: timing counts from the last one
    for (int i = 0; i < 3; i++) apply(mk(1'b0, 1'b1, 1'b0, 0, 8), $sformatf("sw_held%0d", i));
    for (int k = 1; k <= 8; k++) apply(mk(1'b0, 1'b0, 1'b0, k, 8), $sformatf("after_held k%0d", k));

    // Narrow counter saturates at 15
    rst_b = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("b reset reset_out", 32'(ro_b), 32'hf);
    chk("b reset cycle_count", 32'(cnt_b), 32'h0);
    rst_b = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clock); #1;
      if (k == 19) chk("b k19 all_released", 32'(all_b), 32'h0);
      if (k == 20) begin
        chk("b k20 all_released", 32'(all_b), 32'h1);
        chk("b k20 cycle_count", 32'(cnt_b), 32'h0);
      end
      if (k == 34) chk("b k34 cycle_count", 32'(cnt_b), 32'd14);
      if (k == 35) chk("b k35 cycle_count", 32'(cnt_b), 32'd15);
      if (k == 40) chk("b k40 cycle_count", 32'(cnt_b), 32'd15);
    end

    // Single stage, one assert cycle
    rst_c = 1'b1;
    @(posedge clock); #1;
    chk("c reset reset_out", 32'(ro_c), 32'h1);
    chk("c reset busy", 32'(busy_c), 32'h1);
    rst_c = 1'b0;
    @(posedge clock); #1;
    chk("c T0 reset_out", 32'(ro_c), 32'h1);
    chk("c T0 all_released", 32'(all_c), 32'h0);
    @(posedge clock); #1;
    chk("c T1 reset_out", 32'(ro_c), 32'h0);
    chk("c T1 all_released", 32'(all_c), 32'h1);
    chk("c T1 busy", 32'(busy_c), 32'h0);
    chk("c T1 cycle_count", 32'(cnt_c), 32'h0);
    @(posedge clock); #1;
    chk("c T2 cycle_count", 32'(cnt_c), 32'h1);
    sw_c = 1'b1;
    @(posedge clock); #1;
    chk("c sw reset_out", 32'(ro_c), 32'h1);
    chk("c sw cycle_count", 32'(cnt_c), 32'h0);
    sw_c = 1'b0;
    @(posedge clock); #1;
    chk("c sw+1 reset_out", 32'(ro_c), 32'h0);
    chk("c sw+1 all_released", 32'(all_c), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
